// File: rtl/call_return_controller.sv
// call_return_controller
// Return-address stack and single-level interrupt controller that sits beside
// program_sequencer. Decodes CALL/RET/RETI and one level IRQ each cycle and
// drives a same-cycle address override (ovr/ovr_addr) that the sequencer muxes
// ahead of its jmp and pc+1 paths. Stack, depth, FSM and sticky error flags
// update on the next rising clk edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | normal program flow; IRQ may be accepted when stack has room
// S_ISR    | servicing the interrupt; further IRQs masked until legal RETI

module call_return_controller #(
    parameter int         DEPTH      = 8,
    parameter int         SP_W       = 3,
    parameter logic [7:0] IRQ_VECTOR = 8'hF0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      pc,
    input  logic            call,
    input  logic            ret,
    input  logic            reti,
    input  logic [3:0]      call_addr,
    input  logic            irq,
    input  logic            irq_en,
    input  logic            clr_err,
    output logic            ovr,
    output logic [7:0]      ovr_addr,
    output logic            irq_ack,
    output logic            in_isr,
    output logic [SP_W:0]   depth,
    output logic            full,
    output logic            empty,
    output logic            ovf_err,
    output logic            unf_err,
    output logic            cmd_err
);

    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_ISR     = 1'b1;
    localparam logic [SP_W:0]   DEPTH_MAX = (SP_W + 1)'(DEPTH);
    localparam logic [SP_W:0]   DEPTH_ONE = {{SP_W{1'b0}}, 1'b1};
    localparam logic [SP_W-1:0] IDX_ONE   = {{(SP_W-1){1'b0}}, 1'b1};

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [7:0]      stack_mem [DEPTH];

    logic [SP_W-1:0] wr_idx;
    logic [SP_W-1:0] top_idx;
    logic [7:0]      top_data;
    logic [7:0]      pc_inc;
    logic            multi_cmd;

    logic            push_en;
    logic            pop_en;
    logic [7:0]      push_data;
    logic            ovr_c;
    logic [7:0]      ovr_addr_c;
    logic            irq_ack_c;
    logic            ovf_set;
    logic            unf_set;
    logic            cmd_set;

    // Status derived purely from the registered depth.
    always_comb begin
        full    = (depth == DEPTH_MAX);
        empty   = (depth == '0);
        in_isr  = (state == S_ISR);
        wr_idx  = depth[SP_W-1:0];
        // When full, the low bits wrap to 0 and 0-1 lands on DEPTH-1 as needed.
        top_idx = depth[SP_W-1:0] - IDX_ONE;
    end

    // Helper values shared by the decode.
    always_comb begin
        top_data  = stack_mem[top_idx];
        pc_inc    = pc + 8'h01;
        multi_cmd = (call & ret) | (call & reti) | (ret & reti);
    end

    // Command / IRQ decode: instruction commands beat the IRQ; illegal or
    // out-of-bounds commands perform nothing and leave the override low.
    always_comb begin
        push_en    = 1'b0;
        pop_en     = 1'b0;
        push_data  = 8'h00;
        ovr_c      = 1'b0;
        ovr_addr_c = 8'h00;
        irq_ack_c  = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        cmd_set    = 1'b0;
        state_nxt  = state;

        if (multi_cmd) begin
            cmd_set = 1'b1;
        end else if (call) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                push_en    = 1'b1;
                push_data  = pc_inc;
                ovr_c      = 1'b1;
                ovr_addr_c = {call_addr, 4'h0};
            end
        end else if (ret) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                pop_en     = 1'b1;
                ovr_c      = 1'b1;
                ovr_addr_c = top_data;
            end
        end else if (reti) begin
            if (state == S_IDLE) begin
                cmd_set = 1'b1;
            end else begin
                // Leaving the ISR happens even if the stack was unexpectedly empty.
                state_nxt = S_IDLE;
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop_en     = 1'b1;
                    ovr_c      = 1'b1;
                    ovr_addr_c = top_data;
                end
            end
        end else if ((state == S_IDLE) && irq && irq_en && !full) begin
            push_en    = 1'b1;
            push_data  = pc_inc;
            ovr_c      = 1'b1;
            ovr_addr_c = IRQ_VECTOR;
            irq_ack_c  = 1'b1;
            state_nxt  = S_ISR;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    always_comb begin
        ovr      = ovr_c & reset_n;
        ovr_addr = reset_n ? ovr_addr_c : 8'h00;
        irq_ack  = irq_ack_c & reset_n;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stack depth; push and pop are mutually exclusive in the decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (push_en) begin
            depth <= depth + DEPTH_ONE;
        end else if (pop_en) begin
            depth <= depth - DEPTH_ONE;
        end
    end

    // Stack storage; contents are don't-care after reset since depth is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[wr_idx] <= push_data;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            ovf_err <= (ovf_err & ~clr_err) | ovf_set;
            unf_err <= (unf_err & ~clr_err) | unf_set;
            cmd_err <= (cmd_err & ~clr_err) | cmd_set;
        end
    end

endmodule

// File: tb/tb_call_return_controller.sv
// Bench for call_return_controller: directed vector table, hand sequences for
// bounds / ISR / async reset, then random traffic against a queue-based model.

module tb_call_return_controller;

    localparam int DEPTH = 8;
    localparam int SP_W  = 3;

    logic            clk;
    logic            reset_n;
    logic [7:0]      pc;
    logic            call, ret, reti;
    logic [3:0]      call_addr;
    logic            irq, irq_en, clr_err;
    logic            ovr;
    logic [7:0]      ovr_addr;
    logic            irq_ack, in_isr;
    logic [SP_W:0]   depth;
    logic            full, empty, ovf_err, unf_err, cmd_err;

    call_return_controller #(.DEPTH(DEPTH), .SP_W(SP_W), .IRQ_VECTOR(8'hF0)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .call(call), .ret(ret), .reti(reti),
        .call_addr(call_addr), .irq(irq), .irq_en(irq_en), .clr_err(clr_err),
        .ovr(ovr), .ovr_addr(ovr_addr), .irq_ack(irq_ack), .in_isr(in_isr),
        .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: return stack as a queue plus ISR flag and sticky errors.
    logic [7:0] mq[$];
    bit         m_isr, m_ovf, m_unf, m_cmd;

    // Combinational outputs sampled during the last step.
    logic       s_ovr;
    logic [7:0] s_addr;
    logic       s_ack;

    typedef struct {
        logic       c, r, ri;
        logic [3:0] ca;
        logic [7:0] p;
        logic       i, ie, ce;
        logic       e_ovr;
        logic [7:0] e_addr;
        logic       e_ack;
        int         e_depth;
        logic       e_isr, e_ovf, e_unf, e_cmd;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic c, r, ri, input logic [3:0] ca, input logic [7:0] p,
                                input logic i, ie, ce, input logic e_ovr, input logic [7:0] e_addr,
                                input logic e_ack, input int e_depth,
                                input logic e_isr, e_ovf, e_unf, e_cmd);
        vec_t v;
        v.c = c; v.r = r; v.ri = ri; v.ca = ca; v.p = p; v.i = i; v.ie = ie; v.ce = ce;
        v.e_ovr = e_ovr; v.e_addr = e_addr; v.e_ack = e_ack; v.e_depth = e_depth;
        v.e_isr = e_isr; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_cmd = e_cmd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_isr = 0; m_ovf = 0; m_unf = 0; m_cmd = 0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input logic c, r, ri, input logic [3:0] ca, input logic [7:0] p,
                        input logic i, ie, ce);
        int         n;
        logic       e_ovr, e_ack;
        logic [7:0] e_addr, pv;
        bit         psh, pp, nisr, novf, nunf, ncmd;

        call = c; ret = r; reti = ri; call_addr = ca; pc = p; irq = i; irq_en = ie; clr_err = ce;

        n = int'(c) + int'(r) + int'(ri);
        e_ovr = 0; e_addr = 8'h00; e_ack = 0; pv = p + 8'h01;
        psh = 0; pp = 0; nisr = m_isr; novf = 0; nunf = 0; ncmd = 0;
        if (n > 1) ncmd = 1;
        else if (c) begin
            if (mq.size() == DEPTH) novf = 1;
            else begin psh = 1; e_ovr = 1; e_addr = {ca, 4'h0}; end
        end else if (r) begin
            if (mq.size() == 0) nunf = 1;
            else begin pp = 1; e_ovr = 1; e_addr = mq[$]; end
        end else if (ri) begin
            if (!m_isr) ncmd = 1;
            else begin
                nisr = 0;
                if (mq.size() == 0) nunf = 1;
                else begin pp = 1; e_ovr = 1; e_addr = mq[$]; end
            end
        end else if (!m_isr && i && ie && mq.size() < DEPTH) begin
            psh = 1; e_ovr = 1; e_addr = 8'hF0; e_ack = 1; nisr = 1;
        end

        #3;
        s_ovr = ovr; s_addr = ovr_addr; s_ack = irq_ack;
        chk("ovr", 32'(s_ovr), 32'(e_ovr));
        chk("ovr_addr", 32'(s_addr), 32'(e_addr));
        chk("irq_ack", 32'(s_ack), 32'(e_ack));

        @(posedge clk);
        #1;
        if (psh) mq.push_back(pv);
        if (pp) void'(mq.pop_back());
        m_isr = nisr;
        m_ovf = (m_ovf && !ce) || novf;
        m_unf = (m_unf && !ce) || nunf;
        m_cmd = (m_cmd && !ce) || ncmd;

        chk("depth", 32'(depth), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("in_isr", 32'(in_isr), 32'(m_isr));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
        chk("cmd_err", 32'(cmd_err), 32'(m_cmd));
    endtask

    task automatic idle(input logic i, ie, ce);
        step(0, 0, 0, 4'h0, 8'h00, i, ie, ce);
    endtask

    // Asynchronous reset pulse taken away from clock edges; returns at posedge+1.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_depth", 32'(depth), 0);
        chk("rst_in_isr", 32'(in_isr), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_irq_ack", 32'(irq_ack), 0);
        chk("rst_errs", 32'({ovf_err, unf_err, cmd_err}), 0);
        model_reset();
        call = 0; ret = 0; reti = 0; irq = 0; irq_en = 0; clr_err = 0; pc = 8'h00; call_addr = 4'h0;
        #4;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        pc = 8'h00; call_addr = 4'h0;
        call = 1'b1; ret = 1'b0; reti = 1'b0; irq = 1'b1; irq_en = 1'b1; clr_err = 1'b0;
        // Reset asserted mid-cycle with a CALL and IRQ on the inputs: outputs must stay quiet.
        #2;
        reset_n = 1'b0;
        #1;
        chk("init_depth", 32'(depth), 0);
        chk("init_empty", 32'(empty), 1);
        chk("init_in_isr", 32'(in_isr), 0);
        chk("init_ovr", 32'(ovr), 0);
        chk("init_ovr_addr", 32'(ovr_addr), 0);
        chk("init_irq_ack", 32'(irq_ack), 0);
        chk("init_errs", 32'({ovf_err, unf_err, cmd_err}), 0);
        model_reset();
        call = 0; irq = 0; irq_en = 0;
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        //            c  r  ri ca    pc     i  ie ce  ovr addr   ack d  isr ovf unf cmd
        tbl[0]  = mk(1, 0, 0, 4'h3, 8'h12, 0, 0, 0,  1, 8'h30, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 4'h5, 8'h34, 0, 0, 0,  1, 8'h50, 0, 2, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 4'h0, 8'h50, 0, 0, 0,  1, 8'h35, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 4'h0, 8'h35, 0, 0, 0,  1, 8'h13, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 4'h0, 8'h40, 1, 1, 0,  1, 8'hF0, 1, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 4'h0, 8'hF0, 1, 1, 0,  0, 8'h00, 0, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 4'h0, 8'hF1, 0, 1, 0,  1, 8'h41, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 4'h7, 8'h50, 1, 1, 0,  1, 8'h70, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 4'h0, 8'h70, 1, 1, 0,  1, 8'hF0, 1, 2, 1, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 4'h0, 8'hF0, 1, 1, 0,  1, 8'h71, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 4'h0, 8'hF1, 0, 1, 0,  1, 8'h51, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 4'h2, 8'h10, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 1, 4'h0, 8'h11, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 4'h0, 8'h12, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 4'h2, 8'h20, 0, 0, 0,  1, 8'h20, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, 0, 4'h0, 8'h21, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0, 1);
        tbl[16] = mk(1, 0, 1, 4'h0, 8'h22, 0, 0, 1,  0, 8'h00, 0, 1, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 4'h0, 8'h23, 0, 0, 1,  0, 8'h00, 0, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 4'h0, 8'h24, 0, 0, 0,  1, 8'h21, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 4'h0, 8'h25, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 4'h0, 8'h26, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 0, 4'h0, 8'h27, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 22; k++) begin
            step(tbl[k].c, tbl[k].r, tbl[k].ri, tbl[k].ca, tbl[k].p, tbl[k].i, tbl[k].ie, tbl[k].ce);
            chk($sformatf("vec%0d_ovr", k), 32'(s_ovr), 32'(tbl[k].e_ovr));
            chk($sformatf("vec%0d_addr", k), 32'(s_addr), 32'(tbl[k].e_addr));
            chk($sformatf("vec%0d_ack", k), 32'(s_ack), 32'(tbl[k].e_ack));
            chk($sformatf("vec%0d_depth", k), 32'(depth), 32'(tbl[k].e_depth));
            chk($sformatf("vec%0d_isr", k), 32'(in_isr), 32'(tbl[k].e_isr));
            chk($sformatf("vec%0d_errs", k), 32'({ovf_err, unf_err, cmd_err}),
                32'({tbl[k].e_ovf, tbl[k].e_unf, tbl[k].e_cmd}));
        end

        // Bounds: fill the stack, overflow, blocked IRQ, then drain and underflow.
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 4'(k), 8'(8'h80 + k), 0, 0, 0);
        step(1, 0, 0, 4'hA, 8'h90, 0, 0, 0);
        chk("ovf_call_ovr", 32'(s_ovr), 0);
        chk("ovf_flag", 32'(ovf_err), 1);
        chk("ovf_depth", 32'(depth), DEPTH);
        chk("ovf_full", 32'(full), 1);
        idle(1, 1, 0);
        chk("full_irq_blocked", 32'(s_ack), 0);
        step(0, 1, 0, 4'h0, 8'h91, 1, 1, 0);
        chk("ret_beats_irq", 32'(s_ack), 0);
        chk("ret_addr_top", 32'(s_addr), 32'h88);
        idle(1, 1, 0);
        chk("pending_irq_taken", 32'(s_ack), 1);
        chk("pending_irq_isr", 32'(in_isr), 1);
        step(0, 0, 1, 4'h0, 8'hF3, 0, 1, 0);
        chk("reti_addr", 32'(s_addr), 32'h01);
        for (int k = 0; k < DEPTH - 1; k++) step(0, 1, 0, 4'h0, 8'h00, 0, 0, 0);
        step(0, 1, 0, 4'h0, 8'h00, 0, 0, 0);
        chk("unf_ret_ovr", 32'(s_ovr), 0);
        chk("unf_flag", 32'(unf_err), 1);
        chk("unf_empty", 32'(empty), 1);
        idle(0, 0, 1);
        chk("clr_all", 32'({ovf_err, unf_err, cmd_err}), 0);

        // RETI inside ISR with the stack already drained.
        idle(1, 1, 0);
        step(0, 1, 0, 4'h0, 8'hF0, 0, 1, 0);
        step(0, 0, 1, 4'h0, 8'hF1, 0, 1, 0);
        chk("reti_empty_ovr", 32'(s_ovr), 0);
        chk("reti_empty_unf", 32'(unf_err), 1);
        chk("reti_empty_isr", 32'(in_isr), 0);

        // Async reset mid-ISR with entries on the stack.
        idle(0, 0, 1);
        step(0, 0, 0, 4'h0, 8'h60, 1, 1, 0);
        step(1, 0, 0, 4'h4, 8'hF0, 0, 1, 0);
        chk("pre_rst_isr", 32'(in_isr), 1);
        chk("pre_rst_depth", 32'(depth), 2);
        do_reset();

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            logic c, r, ri, i, ie, ce;
            c  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 9) < 3);
            ri = ($urandom_range(0, 9) < 2);
            i  = ($urandom_range(0, 9) < 4);
            ie = ($urandom_range(0, 9) < 7);
            ce = ($urandom_range(0, 19) == 0);
            step(c, r, ri, 4'($urandom), 8'($urandom), i, ie, ce);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
